// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared encodings and defaults for the multiply/divide unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MULT_RUN = 2'd1;
    localparam logic [1:0] S_DIV_RUN  = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = S_IDLE,
        MULT_RUN = S_MULT_RUN,
        DIV_RUN  = S_DIV_RUN,
        DONE     = S_DONE
    } mdu_state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mdu_sign_adjust.sv
// ============================================================================
// Module      : mdu_sign_adjust
// Description : Combinational conditional two's-complement negate.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_sign_adjust
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    // Feeding i_neg with the value's own MSB yields its unsigned magnitude.
    assign o_val = i_neg ? (WIDTH'(0) - i_val) : i_val;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative signed shift-add multiply / restoring divide unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_done,
    output logic             div_done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(1);

    mdu_state_e         r_state;
    mdu_state_e         w_state_nxt;
    logic               r_op;
    logic               r_neg_res;
    logic               r_sign_a;
    logic               r_dbz;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_work_hi;
    logic [WIDTH-1:0]   r_work_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept_mul;
    logic               w_accept_div;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem_nxt;
    logic [WIDTH-1:0]   w_div_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;

    assign w_accept_mul = (r_state == IDLE) && mult_start;
    assign w_accept_div = (r_state == IDLE) && !mult_start && div_start;
    assign w_div_zero   = w_accept_div && (op_b == '0);
    assign w_last       = (r_cnt == c_cnt_last);

    mdu_sign_adjust #(.WIDTH(WIDTH)) u_abs_a (
        .i_val (op_a),
        .i_neg (op_a[WIDTH-1]),
        .o_val (w_abs_a)
    );

    mdu_sign_adjust #(.WIDTH(WIDTH)) u_abs_b (
        .i_val (op_b),
        .i_neg (op_b[WIDTH-1]),
        .o_val (w_abs_b)
    );

    // Multiply: {work_hi, work_lo} is the product register; work_lo starts as the multiplier.
    assign w_mul_sum = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_work_lo[WIDTH-1:1]};

    // Divide: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
    assign w_div_shift   = {r_work_hi, r_work_lo[WIDTH-1]};
    assign w_div_diff    = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge      = !w_div_diff[WIDTH];
    assign w_div_rem_nxt = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_quo_nxt = {r_work_lo[WIDTH-2:0], w_div_ge};

    mdu_sign_adjust #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_val (w_mul_nxt),
        .i_neg (r_neg_res),
        .o_val (w_prod_fix)
    );

    mdu_sign_adjust #(.WIDTH(WIDTH)) u_fix_quo (
        .i_val (w_div_quo_nxt),
        .i_neg (r_neg_res),
        .o_val (w_quo_fix)
    );

    mdu_sign_adjust #(.WIDTH(WIDTH)) u_fix_rem (
        .i_val (w_div_rem_nxt),
        .i_neg (r_sign_a),
        .o_val (w_rem_fix)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != IDLE);
        mult_done   = 1'b0;
        div_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept_mul) begin
                    w_state_nxt = MULT_RUN;
                end else if (w_accept_div) begin
                    w_state_nxt = w_div_zero ? DONE : DIV_RUN;
                end
            end
            MULT_RUN: if (w_last) w_state_nxt = DONE;
            DIV_RUN:  if (w_last) w_state_nxt = DONE;
            DONE: begin
                w_state_nxt = IDLE;
                mult_done   = (r_op == OP_MUL);
                div_done    = (r_op == OP_DIV);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result registers are written only on the transition into DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= OP_MUL;
            r_neg_res <= 1'b0;
            r_sign_a  <= 1'b0;
            r_dbz     <= 1'b0;
            r_cnt     <= '0;
            r_opnd    <= '0;
            r_work_hi <= '0;
            r_work_lo <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept_mul || w_accept_div) begin
                        r_op      <= w_accept_mul ? OP_MUL : OP_DIV;
                        r_opnd    <= w_accept_mul ? w_abs_a : w_abs_b;
                        r_work_lo <= w_accept_mul ? w_abs_b : w_abs_a;
                        r_work_hi <= '0;
                        r_cnt     <= c_cnt_init;
                        r_neg_res <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        r_sign_a  <= op_a[WIDTH-1];
                        r_dbz     <= w_div_zero;
                    end
                    if (w_div_zero) begin
                        r_hi <= op_a;
                        r_lo <= '1;
                    end
                end
                MULT_RUN: begin
                    {r_work_hi, r_work_lo} <= w_mul_nxt;
                    r_cnt                  <= r_cnt - 1'b1;
                    if (w_last) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                DIV_RUN: begin
                    r_work_hi <= w_div_rem_nxt;
                    r_work_lo <= w_div_quo_nxt;
                    r_cnt     <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit with directed vectors.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         mult_start;
    logic         div_start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         mult_done;
    logic         div_done;
    logic         busy;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic         is_div;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t sb[$];

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .op_a        (op_a),
        .op_b        (op_b),
        .hi          (hi),
        .lo          (lo),
        .mult_done   (mult_done),
        .div_done    (div_done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mult_done || div_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {62'd0, mult_done, div_done}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("done_kind", {62'd0, mult_done, div_done}, e.is_div ? 64'd1 : 64'd2);
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
                check("result_dbz", div_by_zero, e.dbz);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    // Called just after a falling edge; returns at the falling edge of cycle 1.
    task automatic issue(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic e_div, input logic [W-1:0] e_hi,
                         input logic [W-1:0] e_lo, input logic e_dbz, input int lat);
        exp_t e;
        mult_start = m;
        div_start  = d;
        op_a       = a;
        op_b       = b;
        if (push) begin
            e = '{e_div, e_hi, e_lo, e_dbz, cyc + lat};
            sb.push_back(e);
        end
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check(name, sb.size(), 64'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset      = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_flags", {60'd0, mult_done, div_done, busy, div_by_zero}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // 7 * -3
        issue(1, 0, 32'd7, 32'hFFFF_FFFD, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33);
        for (int k = 1; k <= 34; k++) begin
            check("busy_window", busy, (k <= 33) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        check("drain_t1", sb.size(), 64'd0);

        // -2^31 * -2^31, then hold for 10 idle cycles
        issue(1, 0, 32'h8000_0000, 32'h8000_0000, 1, 0, 32'h4000_0000, 32'h0000_0000, 0, 33);
        wait_drain("drain_t2", 40);
        repeat (10) @(negedge clk);
        check("hold_after_idle", {hi, lo}, {32'h4000_0000, 32'h0000_0000});

        // -7 / 2, results still valid one cycle after done
        issue(0, 1, 32'hFFFF_FFF9, 32'd2, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 33);
        repeat (33) @(negedge clk);
        check("div_hold_c34", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("div_done_c34", div_done, 64'd0);
        wait_drain("drain_t3", 5);

        // divide by zero, then the overflow case
        issue(0, 1, 32'd100, 32'd0, 1, 1, 32'h0000_0064, 32'hFFFF_FFFF, 1, 1);
        repeat (3) @(negedge clk);
        check("dbz_held", div_by_zero, 64'd1);
        issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h0000_0000, 32'h8000_0000, 0, 33);
        check("dbz_cleared", div_by_zero, 64'd0);
        wait_drain("drain_t4", 40);

        // both starts -> multiply; ignored start while busy; back-to-back at cycle 34
        issue(1, 1, 32'd6, 32'd5, 1, 0, 32'd0, 32'd30, 0, 33);
        repeat (9) @(negedge clk);
        issue(0, 1, 32'd9, 32'd3, 0, 0, '0, '0, 0, 0);
        repeat (23) @(negedge clk);
        issue(1, 0, 32'd2, 32'd3, 1, 0, 32'd0, 32'd6, 0, 33);
        check("busy_after_b2b", busy, 64'd1);
        wait_drain("drain_t5", 40);

        // reset mid-divide, then a fresh multiply
        issue(0, 1, 32'd1000, 32'd7, 0, 0, '0, '0, 0, 0);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midop_reset", {hi, lo}, 64'd0);
        check("midop_busy", busy, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(1, 0, 32'd3, 32'd4, 1, 0, 32'd0, 32'd12, 0, 33);
        wait_drain("drain_t6", 40);
        repeat (40) @(negedge clk);
        check("no_late_done", sb.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
